// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame render control FSM with N-buffer rotation and fixed/free-run swap
module frame_sequencer #(
  parameter int FRAME_PERIOD = 2_000_000,
  parameter int TIMER_WIDTH  = 22,
  parameter int NUM_BUFFERS  = 2,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   mode_in,
  input  logic                   framebuffer_ready_in,
  input  logic                   scene_done_in,
  input  logic                   pixel_valid_in,
  output logic                   matrix_start_out,
  output logic                   fetch_rst_out,
  output logic                   switch_out,
  output logic                   clear_out,
  output logic [1:0]             front_idx_out,
  output logic [1:0]             back_idx_out,
  output logic [COUNT_WIDTH-1:0] pixel_count_out,
  output logic [COUNT_WIDTH-1:0] frame_count_out,
  output logic [COUNT_WIDTH-1:0] dropped_count_out,
  output logic                   busy_out
);
  typedef enum logic [1:0] {WAIT_BUFFER, START, RENDER, DONE} state_t;
  state_t r_state, w_next;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [COUNT_WIDTH-1:0] r_acc, r_pixel_count, r_frame_count, r_dropped, w_acc_inc;
  logic [1:0] r_front, r_back, w_front_nxt, w_back_nxt;
  logic r_matrix_start, r_fetch_rst, r_switch, r_clear, r_busy;
  logic w_tick, w_swap, w_drop;
  assign w_tick = r_timer == TIMER_WIDTH'(FRAME_PERIOD - 1);
  assign w_swap = (r_state == DONE) && (mode_in || w_tick);
  assign w_drop = !mode_in && w_tick && (r_state != DONE);
  assign w_acc_inc = (pixel_valid_in && !(&r_acc)) ? r_acc + COUNT_WIDTH'(1) : r_acc;
  assign w_front_nxt = (r_front == 2'(NUM_BUFFERS - 1)) ? 2'd0 : r_front + 2'd1;
  assign w_back_nxt = (w_front_nxt == 2'(NUM_BUFFERS - 1)) ? 2'd0 : w_front_nxt + 2'd1;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == WAIT_BUFFER && framebuffer_ready_in) ? START :
             (r_state == START) ? RENDER :
             (r_state == RENDER && scene_done_in) ? DONE :
             w_swap ? WAIT_BUFFER : r_state;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= WAIT_BUFFER;
    else r_state <= w_next;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_timer        <= '0;
      r_acc          <= '0;
      r_pixel_count  <= '0;
      r_frame_count  <= '0;
      r_dropped      <= '0;
      r_front        <= 2'd0;
      r_back         <= 2'd1;
      r_matrix_start <= 1'b0;
      r_fetch_rst    <= 1'b1;
      r_switch       <= 1'b0;
      r_clear        <= 1'b1;
      r_busy         <= 1'b0;
    end else begin
      r_timer        <= (w_tick || w_swap) ? '0 : r_timer + TIMER_WIDTH'(1);
      r_matrix_start <= r_state == START;
      r_fetch_rst    <= r_state == WAIT_BUFFER || r_state == DONE;
      r_busy         <= r_state == START || r_state == RENDER;
      r_switch       <= w_swap;
      r_clear        <= w_swap;
      if (w_swap) begin
        r_front <= w_front_nxt;
        r_back  <= w_back_nxt;
      end
      if (r_state == START) r_acc <= '0;
      else if (r_state == RENDER) r_acc <= w_acc_inc;
      if (r_state == RENDER && scene_done_in) begin
        r_pixel_count <= w_acc_inc;
        r_frame_count <= r_frame_count + COUNT_WIDTH'(1);
      end
      if (w_drop && !(&r_dropped)) r_dropped <= r_dropped + COUNT_WIDTH'(1);
    end
  end
  assign matrix_start_out  = r_matrix_start;
  assign fetch_rst_out     = r_fetch_rst;
  assign switch_out        = r_switch;
  assign clear_out         = r_clear;
  assign front_idx_out     = r_front;
  assign back_idx_out      = r_back;
  assign pixel_count_out   = r_pixel_count;
  assign frame_count_out   = r_frame_count;
  assign dropped_count_out = r_dropped;
  assign busy_out          = r_busy;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: vector table, directed corner sequences and randomized model check
module tb_frame_sequencer;
  localparam int P = 50;
  localparam int N = 3;
  localparam int CW = 4;
  localparam int MAXC = 15;
  logic clk = 0;
  logic rst, mode, rdy, done, pv;
  logic ms, fr, sw, clr, busy;
  logic [1:0] front, back;
  logic [CW-1:0] pc, fc, drop;
  int tests = 0;
  int fails = 0;
  int m_timer, m_front, m_pix, m_pc, m_fc, m_drop;
  bit m_start, m_render, m_fin;
  bit e_ms, e_fr, e_sw, e_clr, e_busy;
  typedef struct {
    logic mode, rdy, done, pv;
    logic ms, fr, sw, busy;
    int front, pc, fc;
  } vec_t;
  vec_t tbl[17];
  frame_sequencer #(.FRAME_PERIOD(P), .TIMER_WIDTH(6), .NUM_BUFFERS(N), .COUNT_WIDTH(CW)) dut (
    .clk_in(clk), .rst_in(rst), .mode_in(mode), .framebuffer_ready_in(rdy),
    .scene_done_in(done), .pixel_valid_in(pv), .matrix_start_out(ms), .fetch_rst_out(fr),
    .switch_out(sw), .clear_out(clr), .front_idx_out(front), .back_idx_out(back),
    .pixel_count_out(pc), .frame_count_out(fc), .dropped_count_out(drop), .busy_out(busy)
  );
  always #5 clk = ~clk;
  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction
  task automatic model_edge(input bit r, m, rd, d, p);
    bit tick, swap, waiting;
    if (r) begin
      m_timer = 0; m_front = 0; m_pix = 0; m_pc = 0; m_fc = 0; m_drop = 0;
      m_start = 0; m_render = 0; m_fin = 0;
      e_ms = 0; e_fr = 1; e_sw = 0; e_clr = 1; e_busy = 0;
    end else begin
      tick = m_timer == P - 1;
      swap = m_fin && (m || tick);
      waiting = !(m_start || m_render || m_fin);
      e_ms = m_start;
      e_busy = m_start || m_render;
      e_fr = !e_busy;
      e_sw = swap;
      e_clr = swap;
      if (swap) m_front = (m_front + 1) % N;
      if (!m && tick && !m_fin) m_drop = sat(m_drop + 1);
      if (m_render && d) begin
        m_pc = sat(m_pix + int'(p));
        m_fc = (m_fc + 1) % (MAXC + 1);
      end
      if (m_start) m_pix = 0;
      else if (m_render) m_pix = sat(m_pix + int'(p));
      m_timer = (tick || swap) ? 0 : m_timer + 1;
      m_fin = (m_render && d) || (m_fin && !swap);
      m_render = m_start || (m_render && !d);
      m_start = waiting && rd;
    end
  endtask
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input bit r, m, rd, d, p);
    rst = r; mode = m; rdy = rd; done = d; pv = p;
    @(posedge clk);
    #1;
    model_edge(r, m, rd, d, p);
  endtask
  task automatic compare_all(input string t);
    chk({t, " matrix_start"}, int'(ms), int'(e_ms));
    chk({t, " fetch_rst"}, int'(fr), int'(e_fr));
    chk({t, " switch"}, int'(sw), int'(e_sw));
    chk({t, " clear"}, int'(clr), int'(e_clr));
    chk({t, " busy"}, int'(busy), int'(e_busy));
    chk({t, " front"}, int'(front), m_front);
    chk({t, " back"}, int'(back), (m_front + 1) % N);
    chk({t, " pixel_count"}, int'(pc), m_pc);
    chk({t, " frame_count"}, int'(fc), m_fc);
    chk({t, " dropped"}, int'(drop), m_drop);
  endtask
  task automatic run_frame(input int npix);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < npix; i++) step(0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
  endtask
  initial begin
    bit mode_r;
    tbl = '{
      '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0},
      '{1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0},
      '{1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0},
      '{1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0},
      '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0},
      '{1, 0, 1, 1, 0, 0, 0, 1, 0, 3, 1},
      '{1, 0, 0, 0, 0, 1, 1, 0, 1, 3, 1},
      '{1, 0, 0, 0, 0, 1, 0, 0, 1, 3, 1},
      '{1, 0, 1, 1, 0, 1, 0, 0, 1, 3, 1},
      '{1, 1, 0, 0, 0, 1, 0, 0, 1, 3, 1},
      '{1, 0, 0, 0, 1, 0, 0, 1, 1, 3, 1},
      '{1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 2},
      '{1, 0, 0, 0, 0, 1, 1, 0, 2, 0, 2},
      '{1, 1, 0, 0, 0, 1, 0, 0, 2, 0, 2},
      '{1, 0, 0, 0, 1, 0, 0, 1, 2, 0, 2},
      '{1, 0, 1, 1, 0, 0, 0, 1, 2, 1, 3},
      '{1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 3}
    };
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    chk("reset fetch_rst", int'(fr), 1);
    chk("reset clear", int'(clr), 1);
    chk("reset switch", int'(sw), 0);
    chk("reset matrix_start", int'(ms), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset front", int'(front), 0);
    chk("reset back", int'(back), 1);
    chk("reset counters", int'(pc) + int'(fc) + int'(drop), 0);
    for (int i = 0; i < 17; i++) begin
      step(0, tbl[i].mode, tbl[i].rdy, tbl[i].done, tbl[i].pv);
      chk($sformatf("vec%0d matrix_start", i), int'(ms), int'(tbl[i].ms));
      chk($sformatf("vec%0d fetch_rst", i), int'(fr), int'(tbl[i].fr));
      chk($sformatf("vec%0d switch", i), int'(sw), int'(tbl[i].sw));
      chk($sformatf("vec%0d clear", i), int'(clr), int'(tbl[i].sw));
      chk($sformatf("vec%0d busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("vec%0d front", i), int'(front), tbl[i].front);
      chk($sformatf("vec%0d back", i), int'(back), (tbl[i].front + 1) % N);
      chk($sformatf("vec%0d pixel_count", i), int'(pc), tbl[i].pc);
      chk($sformatf("vec%0d frame_count", i), int'(fc), tbl[i].fc);
    end
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 150; k++) begin
      step(0, 0, k == 1 || k == 51, k == 20 || k == 110, k >= 3 && k <= 12);
      chk($sformatf("fixed switch k=%0d", k), int'(sw), int'(k == 50 || k == 150));
      if (k == 1) chk("fixed matrix_start early", int'(ms), 0);
      if (k == 2) chk("fixed matrix_start", int'(ms), 1);
      if (k == 2) chk("fixed fetch_rst start", int'(fr), 0);
      if (k == 50) begin
        chk("fixed front", int'(front), 1);
        chk("fixed pixel_count", int'(pc), 10);
        chk("fixed frame_count", int'(fc), 1);
        chk("fixed dropped none", int'(drop), 0);
      end
      if (k == 99) chk("overrun before tick", int'(drop), 0);
      if (k == 100) chk("overrun dropped", int'(drop), 1);
      if (k == 150) begin
        chk("overrun front", int'(front), 2);
        chk("overrun frame_count", int'(fc), 2);
        chk("overrun dropped hold", int'(drop), 1);
      end
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("midrst fetch_rst", int'(fr), 1);
    chk("midrst switch", int'(sw), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst frame_count", int'(fc), 0);
    chk("midrst dropped", int'(drop), 0);
    chk("midrst front", int'(front), 0);
    step(0, 0, 0, 0, 0);
    chk("midrst no switch after", int'(sw), 0);
    step(1, 1, 0, 0, 0);
    run_frame(20);
    chk("sat pixel_count", int'(pc), 15);
    chk("sat frame_count", int'(fc), 1);
    for (int i = 0; i < 14; i++) run_frame(0);
    chk("wrap frame_count 15", int'(fc), 15);
    run_frame(2);
    chk("wrap frame_count 0", int'(fc), 0);
    chk("wrap pixel_count", int'(pc), 2);
    step(1, 0, 0, 0, 0);
    mode_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) mode_r = ~mode_r;
      step($urandom_range(199) == 0, mode_r, $urandom_range(3) == 0,
           $urandom_range(7) == 0, $urandom_range(1) == 1);
      compare_all($sformatf("rand%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
